user_strm_loopback_mc: RTL
==========================

// Module: user_strm_loopback_mc
// PURPOSE
//  Parametrised multi-channel stream engine for the vFPGA user-logic slot (stream, card, RDMA or TCP path).
//  Each channel buffers recv beats in a FIFO and re-emits them on send in one of three modes:
//   - loopback
//   - per-32b-lane add
//   - drop
//  Per-channel enable is gated at packet boundaries. Packet and beat counters are kept per channel.
//  The block replaces the bare combinational loopback and sits between the shell stream arrays and host-visible control/status.
//
// PARAMETERS
//  N_CH       2    number of independent channels (1..16)
//  DATA_BITS  512  tdata width; multiple of 32
//  PID_BITS   6    tid width (passed through unchanged)
//  FIFO_DEPTH 16   beats per channel FIFO; power of 2, >=2
//
// PORTS
//  aclk         in   1                 clock, all logic rising-edge
//  aresetn      in   1                 asynchronous active-low reset
//  s_tvalid     in   N_CH              recv valid per channel
//  s_tready     out  N_CH              recv ready per channel
//  s_tdata      in   N_CH*DATA_BITS    recv data, channel c at [c*DATA_BITS +: DATA_BITS]
//  s_tkeep      in   N_CH*DATA_BITS/8  recv byte enables
//  s_tlast      in   N_CH              recv end of packet
//  s_tid        in   N_CH*PID_BITS     recv id
//  m_tvalid     out  N_CH              send valid
//  m_tready     in   N_CH              send ready
//  m_tdata      out  N_CH*DATA_BITS    send data
//  m_tkeep      out  N_CH*DATA_BITS/8  send byte enables
//  m_tlast      out  N_CH              send end of packet
//  m_tid        out  N_CH*PID_BITS     send id
//  ctrl_en      in   N_CH              channel enable request
//  ctrl_mode    in   2*N_CH            0 loopback, 1 add, 2 drop, 3 = loopback
//  ctrl_addend  in   32                lane addend for mode 1
//  cnt_clr      in   1                 synchronous clear of all counters
//  stat_active  out  N_CH              effective (boundary-gated) enable
//  stat_pkts    out  32*N_CH           packets emitted (send tlast accepted; drop mode counts input tlast)
//  stat_beats   out  32*N_CH           beats accepted on recv
//
// BEHAVIOUR
//  Reset (async assert, sync-deassert assumed upstream). All outputs go to 0:
//   - s_tready, m_tvalid, stat_active = 0; counters = 0; FIFOs empty.
//   - Per-channel FSM in IDLE.
//  Per-channel FSM, states IDLE / IN_PKT / OFF:
//   - IDLE: stat_active = ctrl_en[c]. If ctrl_en = 0, go to OFF.
//     On first accepted beat: latch mode_r = ctrl_mode[c]; if tlast = 0, go to IN_PKT, else stay in IDLE.
//   - IN_PKT: mode_r frozen; ctrl_en changes ignored; on accepted tlast, go to IDLE.
//   - OFF: s_tready = 0, stat_active = 0; ctrl_en = 1 returns to IDLE next cycle.
//     The FIFO still drains on send while in OFF.
//  Mode 3 is treated as mode 0 when latched.
//  Handshake:
//   - Beat accepted when s_tvalid & s_tready; s_tready = active & ~fifo_full. No combinational path from m_tready to s_tready.
//   - Modes 0/1: beat written to the FIFO. Mode 2: beat discarded; s_tready = active (never stalls).
//   - m_tvalid = ~fifo_empty; m_t* come from a FIFO register output. Once m_tvalid is high, data holds stable until m_tready.
//   - Latency: beat accepted in cycle N appears on m_* in cycle N+1 if the FIFO was empty.
//   - Full and simultaneous pop: s_tready stays 0 that cycle (no same-cycle refill). Full throughput = 1 beat/cycle when not full.
//  Arithmetic (mode 1): each 32b lane i of tdata = lane + ctrl_addend, mod 2^32, computed at write.
//   - ctrl_addend is sampled per beat.
//   - tkeep, tlast and tid pass unchanged; lanes with tkeep = 0 are still added.
//  Counters:
//   - 32b, wrap 0xFFFF_FFFF -> 0.
//   - cnt_clr has priority over a same-cycle increment; the result is 0.
//  FIFO pointers: log2(FIFO_DEPTH)+1 bits; full = MSB differ & rest equal.
//  Channels are fully independent; there is no cross-channel arbitration.
//
// TESTING
//  1. Mode 0, ch0, 4-beat packet (data 0..3, tlast on beat 3), m_tready = 1 -> identical beats one cycle later.
//     stat_pkts[0] = 1, stat_beats[0] = 4.
//  2. Mode 1, addend 0xFFFF_FFFF, lane 0x0000_0005 -> output lane 0x0000_0004 (wrap); tkeep/tid unchanged.
//  3. m_tready = 0, stream 20 beats into FIFO_DEPTH = 16 -> s_tready drops after beat 16.
//     Release m_tready -> all 20 beats delivered in order, none lost.
//  4. ctrl_en deasserted mid-packet (beat 2 of 5) -> remaining 3 beats accepted, then s_tready = 0 and stat_active = 0.
//     Re-enable -> next packet flows.
//  5. Mode 2, 3 packets -> m_tvalid never asserts, stat_pkts = 3, s_tready constantly 1.
//     ch1 in mode 0 concurrently runs unaffected.
//  6. aresetn pulsed low mid-packet with a full FIFO -> outputs 0 asynchronously, counters 0.
//     First post-reset packet loops back cleanly.

Source files
------------

// File: rtl/user_strm_loopback_mc.sv
`default_nettype none
// ============================================================================
//  Module      : user_strm_loopback_mc
//  Description : Multi-channel stream engine for the vFPGA user-logic slot.
//                Each channel buffers recv beats in a FIFO and re-emits them
//                as loopback, per-32b-lane add, or drops them. The channel
//                enable only takes effect at packet boundaries. Each channel
//                keeps its own packet and beat counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module user_strm_loopback_mc #(
   parameter int N_CH       = 2,
   parameter int DATA_BITS  = 512,
   parameter int PID_BITS   = 6,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N_CH-1:0]               s_tvalid,
   output logic [N_CH-1:0]               s_tready,
   input  logic [N_CH*DATA_BITS-1:0]     s_tdata,
   input  logic [N_CH*DATA_BITS/8-1:0]   s_tkeep,
   input  logic [N_CH-1:0]               s_tlast,
   input  logic [N_CH*PID_BITS-1:0]      s_tid,
   output logic [N_CH-1:0]               m_tvalid,
   input  logic [N_CH-1:0]               m_tready,
   output logic [N_CH*DATA_BITS-1:0]     m_tdata,
   output logic [N_CH*DATA_BITS/8-1:0]   m_tkeep,
   output logic [N_CH-1:0]               m_tlast,
   output logic [N_CH*PID_BITS-1:0]      m_tid,
   input  logic [N_CH-1:0]               ctrl_en,
   input  logic [2*N_CH-1:0]             ctrl_mode,
   input  logic [31:0]                   ctrl_addend,
   input  logic                          cnt_clr,
   output logic [N_CH-1:0]               stat_active,
   output logic [32*N_CH-1:0]            stat_pkts,
   output logic [32*N_CH-1:0]            stat_beats
);

   localparam int KEEP_BITS = DATA_BITS / 8;
   localparam int LANES     = DATA_BITS / 32;
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int EW        = PID_BITS + 1 + KEEP_BITS + DATA_BITS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IN_PKT = 2'd1;
   localparam logic [1:0] ST_OFF    = 2'd2;

   localparam logic [1:0] MODE_LOOP = 2'd0;
   localparam logic [1:0] MODE_ADD  = 2'd1;
   localparam logic [1:0] MODE_DROP = 2'd2;

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   genvar c;
   generate
      for (c = 0; c < N_CH; c++) begin : g_ch
         logic [1:0]           state_q, state_d;
         logic [1:0]           mode_q, mode_d;
         logic [1:0]           req_mode;
         logic [1:0]           cur_mode;
         logic                 active;
         logic                 rdy;
         logic                 acc;
         logic                 wr_en;
         logic                 rd_en;
         logic                 full;
         logic                 empty;
         logic [AW:0]          wr_ptr_q, rd_ptr_q;
         logic [EW-1:0]        mem_q [FIFO_DEPTH];
         logic [EW-1:0]        rd_word;
         logic [DATA_BITS-1:0] in_data;
         logic [DATA_BITS-1:0] wr_data;
         logic [31:0]          pkts_q, beats_q;
         logic [1:0]           pkt_inc;

         // Mode 3 is an alias of loopback.
         assign req_mode = (ctrl_mode[2*c +: 2] == 2'd3) ? MODE_LOOP : ctrl_mode[2*c +: 2];
         assign in_data  = s_tdata[c*DATA_BITS +: DATA_BITS];

         // Channel FSM state and latched packet mode.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               state_q <= ST_IDLE;
               mode_q  <= MODE_LOOP;
            end else begin
               state_q <= state_d;
               mode_q  <= mode_d;
            end
         end

         // Next state: enable changes only act outside a packet.
         always_comb begin
            state_d = state_q;
            mode_d  = mode_q;
            case (state_q)
               ST_IDLE: begin
                  if (!ctrl_en[c]) begin
                     state_d = ST_OFF;
                  end else if (acc) begin
                     mode_d = req_mode;
                     if (!s_tlast[c]) state_d = ST_IN_PKT;
                  end
               end
               ST_IN_PKT: begin
                  if (acc && s_tlast[c]) state_d = ST_IDLE;
               end
               ST_OFF: begin
                  if (ctrl_en[c]) state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end

         // FSM outputs: effective enable and the mode applied to the current beat.
         always_comb begin
            active   = 1'b0;
            cur_mode = mode_q;
            case (state_q)
               ST_IDLE: begin
                  active   = ctrl_en[c];
                  cur_mode = req_mode;
               end
               ST_IN_PKT: active = 1'b1;
               default:   active = 1'b0;
            endcase
         end

         // Ready depends only on local occupancy, never on m_tready; drop mode never stalls.
         assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
         assign empty = (wr_ptr_q == rd_ptr_q);
         assign rdy   = active & ((cur_mode == MODE_DROP) | ~full);
         assign acc   = s_tvalid[c] & rdy;
         assign wr_en = acc & (cur_mode != MODE_DROP);
         assign rd_en = ~empty & m_tready[c];

         // Lane-wise add with the addend sampled on the accepted beat.
         always_comb begin
            wr_data = in_data;
            if (cur_mode == MODE_ADD) begin
               for (int i = 0; i < LANES; i++) begin
                  wr_data[i*32 +: 32] = in_data[i*32 +: 32] + ctrl_addend;
               end
            end
         end

         // FIFO storage; contents need no reset since the pointers define validity.
         always_ff @(posedge aclk) begin
            if (wr_en) begin
               mem_q[wr_ptr_q[AW-1:0]] <= {s_tid[c*PID_BITS +: PID_BITS], s_tlast[c],
                                          s_tkeep[c*KEEP_BITS +: KEEP_BITS], wr_data};
            end
         end

         // FIFO pointers with an extra wrap bit to tell full from empty.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
            end else begin
               if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
               if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
         end

         assign rd_word = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

         // A drained tlast and a dropped tlast can land in the same cycle.
         assign pkt_inc = {1'b0, rd_en & rd_word[EW-PID_BITS-1]}
                        + {1'b0, acc & (cur_mode == MODE_DROP) & s_tlast[c]};

         // Packet and beat counters; clear wins over a same-cycle increment.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               pkts_q  <= '0;
               beats_q <= '0;
            end else if (cnt_clr) begin
               pkts_q  <= '0;
               beats_q <= '0;
            end else begin
               pkts_q  <= pkts_q + {30'd0, pkt_inc};
               beats_q <= beats_q + {31'd0, acc};
            end
         end

         assign s_tready[c]    = aresetn & rdy;
         assign stat_active[c] = aresetn & active;
         assign m_tvalid[c]    = ~empty;
         assign m_tdata[c*DATA_BITS +: DATA_BITS] = rd_word[DATA_BITS-1:0];
         assign m_tkeep[c*KEEP_BITS +: KEEP_BITS] = rd_word[DATA_BITS +: KEEP_BITS];
         assign m_tlast[c]                        = rd_word[EW-PID_BITS-1];
         assign m_tid[c*PID_BITS +: PID_BITS]     = rd_word[EW-1 -: PID_BITS];
         assign stat_pkts[c*32 +: 32]             = pkts_q;
         assign stat_beats[c*32 +: 32]            = beats_q;
      end
   endgenerate

endmodule
`default_nettype wire
